// File: rtl/xadac_pkg.sv
// xadac_pkg: shared types and constants for the xadac vector unit.
//   NoVec           number of architectural vector registers
//   VecAddrT        vector register index
//   VecDataT        vector register write data
//   NoWbSrcDefault  default number of write-back sources
//   WbReqT          one queued write-back request {addr, data}
//   addr_onehot()   one-hot decode of a register index, used for pending masks
package xadac_pkg;

    localparam int unsigned NoVec          = 32;
    localparam int unsigned VecAddrW       = $clog2(NoVec);
    localparam int unsigned VecDataW       = 32;
    localparam int unsigned NoWbSrcDefault = 2;

    typedef logic [VecAddrW-1:0] VecAddrT;
    typedef logic [VecDataW-1:0] VecDataT;

    typedef struct packed {
        VecAddrT addr;
        VecDataT data;
    } WbReqT;

    function automatic logic [NoVec-1:0] addr_onehot(input VecAddrT a);
        logic [NoVec-1:0] oh;
        oh    = {NoVec{1'b0}};
        oh[a] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/xadac_vrf_wb_chk.sv
// xadac_vrf_wb_chk: simulation-only invariants of the write-back collector.
// Ports (all inputs): clk, rst, per-source push/pop/full/empty and the
// per-slot valid/address views of every source FIFO.
// Checks: no push into a full FIFO, no pop from an empty FIFO, and no two
// queued writes to the same register.
module xadac_vrf_wb_chk
    import xadac_pkg::*;
#(
    parameter int unsigned NoWbSrc   = NoWbSrcDefault,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NoWbSrc-1:0]                   push,
    input  logic [NoWbSrc-1:0]                   pop,
    input  logic [NoWbSrc-1:0]                   full,
    input  logic [NoWbSrc-1:0]                   empty,
    input  logic [NoWbSrc-1:0][FifoDepth-1:0]    ent_valid,
    input  VecAddrT [NoWbSrc-1:0][FifoDepth-1:0] ent_addr
);

    logic dup_s;

    // Any pair of distinct valid slots holding the same destination.
    always_comb begin
        dup_s = 1'b0;
        for (int unsigned s1 = 0; s1 < NoWbSrc; s1++) begin
            for (int unsigned d1 = 0; d1 < FifoDepth; d1++) begin
                for (int unsigned s2 = 0; s2 < NoWbSrc; s2++) begin
                    for (int unsigned d2 = 0; d2 < FifoDepth; d2++) begin
                        dup_s = dup_s | (((s1 * FifoDepth + d1) < (s2 * FifoDepth + d2)) &&
                                         ent_valid[s1][d1] && ent_valid[s2][d2] &&
                                         (ent_addr[s1][d1] == ent_addr[s2][d2]));
                    end
                end
            end
        end
    end

    // Invariants sampled at every rising edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(|(push & full)))  else $error("xadac_vrf_wb_chk: push into full FIFO");
            assert (!(|(pop & empty)))  else $error("xadac_vrf_wb_chk: pop from empty FIFO");
            assert (!dup_s)             else $error("xadac_vrf_wb_chk: duplicate queued destination");
        end
    end

endmodule

// File: rtl/xadac_wb_fifo.sv
// xadac_wb_fifo: in-order FIFO of WbReqT for one write-back source.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_req  enqueue request (caller guarantees !full)
//   pop             dequeue head (caller guarantees !empty)
//   head            oldest entry
//   full, empty     occupancy flags, from registered count only
//   ent_valid       per-slot valid bits
//   ent_addr        per-slot destination address (meaningful where ent_valid)
module xadac_wb_fifo
    import xadac_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  WbReqT                   push_req,
    input  logic                    pop,
    output WbReqT                   head,
    output logic                    full,
    output logic                    empty,
    output logic [Depth-1:0]        ent_valid,
    output VecAddrT [Depth-1:0]     ent_addr
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    WbReqT             mem_r [Depth];
    logic [Depth-1:0]  valid_r;
    logic [Depth-1:0]  valid_nxt_s;
    logic [PtrW-1:0]   wr_ptr_r;
    logic [PtrW-1:0]   rd_ptr_r;
    logic [CntW-1:0]   count_r;
    logic [CntW-1:0]   count_nxt_s;

    // Circular pointer advance; Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? {PtrW{1'b0}} : p + PtrW'(1);
    endfunction

    // Next slot-valid and occupancy; push and pop never hit the same slot.
    always_comb begin
        valid_nxt_s = (valid_r | (Depth'(push) << wr_ptr_r)) & ~(Depth'(pop) << rd_ptr_r);
        case ({push, pop})
            2'b10:   count_nxt_s = count_r + CntW'(1);
            2'b01:   count_nxt_s = count_r - CntW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
            valid_r  <= {Depth{1'b0}};
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_r[i] <= '{addr: {VecAddrW{1'b0}}, data: {VecDataW{1'b0}}};
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_req;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    // Registered-state views for the arbiter and the pending mask.
    always_comb begin
        head      = mem_r[rd_ptr_r];
        full      = (count_r == CntW'(Depth));
        empty     = (count_r == {CntW{1'b0}});
        ent_valid = valid_r;
        for (int unsigned i = 0; i < Depth; i++) begin
            ent_addr[i] = mem_r[i].addr;
        end
    end

endmodule

// File: rtl/xadac_vrf_wb.sv
// xadac_vrf_wb: write-back collector for the xadac vector register file.
// Each source has a valid/ready channel into its own FIFO; a round-robin
// arbiter drains the FIFOs onto the single register-file write port.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   src_valid/src_ready           per-source handshake
//   src_addr/src_data             per-source destination register and data
//   vrf_waddr/vrf_wdata/vrf_we    register-file write port
//   pend_mask                     bit r set while a write to register r is queued
// Build option: XADAC_VRF_WB_BYPASS_EN - when every FIFO is empty, one valid
// source is written straight through in the same cycle (not enqueued).
module xadac_vrf_wb
    import xadac_pkg::*;
#(
    parameter int unsigned NoWbSrc   = NoWbSrcDefault,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NoWbSrc-1:0]       src_valid,
    output logic [NoWbSrc-1:0]       src_ready,
    input  VecAddrT [NoWbSrc-1:0]    src_addr,
    input  VecDataT [NoWbSrc-1:0]    src_data,
    output VecAddrT                  vrf_waddr,
    output VecDataT                  vrf_wdata,
    output logic                     vrf_we,
    output logic [NoVec-1:0]         pend_mask
);

    localparam int unsigned RrW = (NoWbSrc > 1) ? $clog2(NoWbSrc) : 1;

    logic [RrW-1:0]                       rr_q;
    logic [NoWbSrc-1:0]                   push_s;
    logic [NoWbSrc-1:0]                   pop_s;
    logic [NoWbSrc-1:0]                   full_s;
    logic [NoWbSrc-1:0]                   empty_s;
    WbReqT [NoWbSrc-1:0]                  in_req_s;
    WbReqT [NoWbSrc-1:0]                  head_s;
    logic [NoWbSrc-1:0][FifoDepth-1:0]    ent_valid_s;
    VecAddrT [NoWbSrc-1:0][FifoDepth-1:0] ent_addr_s;
    logic                                 grant_s;
    logic [RrW-1:0]                       grant_idx_s;
    logic                                 byp_s;
    logic [RrW-1:0]                       byp_idx_s;

    // Source index at offset 'off' from 'base', wrapping at NoWbSrc.
    function automatic logic [RrW-1:0] rot_idx(input logic [RrW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        return RrW'((sum >= NoWbSrc) ? sum - NoWbSrc : sum);
    endfunction

    // Pointer value following a grant to source w.
    function automatic logic [RrW-1:0] next_rr(input logic [RrW-1:0] w);
        return (w == RrW'(NoWbSrc - 1)) ? {RrW{1'b0}} : w + RrW'(1);
    endfunction

    // Ready depends only on registered occupancy: a full FIFO refuses even while draining.
    assign src_ready = ~full_s;

    for (genvar s = 0; s < NoWbSrc; s++) begin : g_src
        xadac_wb_fifo #(
            .Depth (FifoDepth)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_s[s]),
            .push_req  (in_req_s[s]),
            .pop       (pop_s[s]),
            .head      (head_s[s]),
            .full      (full_s[s]),
            .empty     (empty_s[s]),
            .ent_valid (ent_valid_s[s]),
            .ent_addr  (ent_addr_s[s])
        );
    end

    // First non-empty FIFO scanning upward from rr_q with wrap-around.
    always_comb begin : arb_scan
        logic [RrW-1:0] idx;
        logic           take;
        grant_s     = 1'b0;
        grant_idx_s = {RrW{1'b0}};
        for (int unsigned i = 0; i < NoWbSrc; i++) begin
            idx         = rot_idx(rr_q, i);
            take        = !grant_s && !empty_s[idx];
            grant_idx_s = take ? idx : grant_idx_s;
            grant_s     = grant_s | take;
        end
    end

    // Straight-through candidate, only when no FIFO holds anything.
    always_comb begin : byp_scan
        byp_s     = 1'b0;
        byp_idx_s = {RrW{1'b0}};
`ifdef XADAC_VRF_WB_BYPASS_EN
        for (int unsigned i = 0; i < NoWbSrc; i++) begin
            byp_idx_s = (!byp_s && src_valid[rot_idx(rr_q, i)]) ? rot_idx(rr_q, i) : byp_idx_s;
            byp_s     = byp_s | src_valid[rot_idx(rr_q, i)];
        end
        byp_s = byp_s & !grant_s & !rst;
`endif
    end

    // Enqueue everything accepted except a source taken straight through.
    always_comb begin
        for (int unsigned s = 0; s < NoWbSrc; s++) begin
            in_req_s[s].addr = src_addr[s];
            in_req_s[s].data = src_data[s];
            push_s[s] = src_valid[s] & src_ready[s] & ~(byp_s & (byp_idx_s == RrW'(s)));
        end
    end

    // Write port and FIFO pop; nothing issues while reset is asserted.
    always_comb begin
        pop_s     = {NoWbSrc{1'b0}};
        vrf_we    = 1'b0;
        vrf_waddr = {VecAddrW{1'b0}};
        vrf_wdata = {VecDataW{1'b0}};
        if (rst) begin
            vrf_we = 1'b0;
        end else if (grant_s) begin
            pop_s[grant_idx_s] = 1'b1;
            vrf_we             = 1'b1;
            vrf_waddr          = head_s[grant_idx_s].addr;
            vrf_wdata          = head_s[grant_idx_s].data;
        end else if (byp_s) begin
            vrf_we    = 1'b1;
            vrf_waddr = src_addr[byp_idx_s];
            vrf_wdata = src_data[byp_idx_s];
        end else begin
            vrf_we = 1'b0;
        end
    end

    // Round-robin pointer: advance past the winner, hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= {RrW{1'b0}};
        end else if (grant_s) begin
            rr_q <= next_rr(grant_idx_s);
        end else if (byp_s) begin
            rr_q <= next_rr(byp_idx_s);
        end else begin
            rr_q <= rr_q;
        end
    end

    // Pending mask: OR of one-hot destinations of every queued entry.
    always_comb begin
        pend_mask = {NoVec{1'b0}};
        for (int unsigned s = 0; s < NoWbSrc; s++) begin
            for (int unsigned d = 0; d < FifoDepth; d++) begin
                pend_mask = pend_mask |
                            (ent_valid_s[s][d] ? addr_onehot(ent_addr_s[s][d]) : {NoVec{1'b0}});
            end
        end
    end

    xadac_vrf_wb_chk #(
        .NoWbSrc   (NoWbSrc),
        .FifoDepth (FifoDepth)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .full      (full_s),
        .empty     (empty_s),
        .ent_valid (ent_valid_s),
        .ent_addr  (ent_addr_s)
    );

endmodule
